sobel_frame_sequencer: RTL and testbench
========================================

Name: sobel_frame_sequencer

Overview:
Frame-level controller for the Sobel/Prewitt edge datapath. It raster-scans a WIDTH x HEIGHT 8-bit image held in a 1-cycle-latency image RAM and, for each interior pixel, fetches the 3x3 neighbourhood and presents it to the convolution engine over a valid/ready handshake. It then collects the engine's result and writes it to the output RAM. Border pixels are written as 0 without invoking the engine. It replaces the free-running flag-passing between the window, convolution and output processes with one explicit FSM.

Parameters:
WIDTH, 45, image width in pixels (>=3)
HEIGHT, 45, image height in pixels (>=3)
ADDR_W, 19, RAM address width; must satisfy WIDTH*HEIGHT <= 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin a frame; sampled only in IDLE
kernel_sel  in  1  0 = Sobel, 1 = Prewitt; latched when start is accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last output write
rd_en  out  1  image RAM read strobe
rd_addr  out  ADDR_W  image RAM address
rd_data  in  8  read data, valid the cycle after rd_en
win_valid  out  1  window offered to the engine
win_ready  in  1  engine accepts the window
win_data  out  72  9 pixels packed; [7:0] = top-left, row-major, [71:64] = bottom-right
win_kernel  out  1  latched kernel_sel, held for the whole frame
res_valid  in  1  engine result available
res_pixel  in  8  engine result, already thresholded
res_ready  out  1  sequencer accepts the result
wr_en  out  1  output RAM write strobe
wr_addr  out  ADDR_W  output address = row*WIDTH+col
wr_data  out  8  output pixel

Behaviour:
- Reset (rst=0, async): state IDLE. busy, done, rd_en, win_valid, res_ready and wr_en are 0. rd_addr, wr_addr, wr_data, win_data and win_kernel are 0. Row and column counters are 0. Reset asserted mid-frame aborts the frame immediately: no further writes and no done pulse.
- States: IDLE, FETCH, PRESENT, WAIT_RES, WRITE, DONE.
- IDLE: when start=1, latch kernel_sel, set row=col=0, busy=1, and go to WRITE if (0,0) is a border pixel, else FETCH. start is ignored in all other states.
- Border pixel: row==0, row==HEIGHT-1, col==0 or col==WIDTH-1. It goes straight to WRITE with wr_data=0 and takes 1 cycle.
- FETCH: rd_en=1 for 9 consecutive cycles at addresses (row-1+dy)*WIDTH+(col-1+dx), with dy outer and dx inner, each 0..2. Each rd_data is captured into its window slot the cycle after its read. FETCH lasts 10 cycles, then PRESENT.
- PRESENT: win_valid=1 and win_data is stable until win_ready=1. The handshake completes on the edge where win_valid and win_ready are both 1, then go to WAIT_RES.
- WAIT_RES: res_ready=1. On the edge where res_valid=1, capture res_pixel into wr_data and go to WRITE. res_valid in any other state is ignored; the engine must hold it.
- WRITE: wr_en=1 for exactly one cycle with wr_addr=row*WIDTH+col. Then advance col, wrapping to 0 and incrementing row at WIDTH-1. If the pixel just written was the last (row=HEIGHT-1, col=WIDTH-1), go to DONE. Otherwise go to FETCH or WRITE according to the border test on the new pixel.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Minimum interior pixel cost with zero-wait handshakes: 13 cycles (10+1+1+1).
- Frame length to the done cycle with zero-wait handshakes: B + 13*I + 1 cycles after the start edge, where B = border count and I = interior count. For 45x45: B=176, I=1849.
- Address arithmetic is unsigned ADDR_W; no wrap occurs within a valid frame.

Decomposition:
- sobel_pkg: state enum, KERNEL_SOBEL=0 / KERNEL_PREWITT=1, WIN_PIXELS=9, PIX_W=8, WIN_W=72.
- Sub-module sobel_win_fetch: the 9-read address generator plus window capture register, with a start/done handshake to the FSM.

Test Plan:
- WIDTH=4, HEIGHT=3, all zero-wait, ramp image (pixel=addr): rd_addr sequence for (1,1) is 0,1,2,4,5,6,8,9,10; done arrives 37 cycles after the start edge; 12 writes total; addresses 0..3, 4, 7, 8..11 carry 0.
- 45x45 zero-wait, engine returns 0xAA: exactly 2025 writes with each address written once; 176 zeros; 1849 writes of 0xAA; done exactly once.
- win_ready held low 5 cycles in PRESENT: win_valid and win_data stay stable for those cycles and there is no rd_en; one write occurs after ready.
- res_valid pulsed in FETCH and then again in WAIT_RES: only the WAIT_RES value is written.
- rst driven low during FETCH of pixel (1,2): all outputs 0 asynchronously; after release, the FSM is in IDLE and a new start re-runs from address 0.
- start asserted while busy, with kernel_sel toggled mid-frame: ignored; win_kernel holds the value latched at frame start.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel/Prewitt frame sequencer.
//   - FSM state encoding
//   - kernel select encodings
//   - pixel / window geometry
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int WIN_PIXELS = 9;
  localparam int WIN_W      = PIX_W * WIN_PIXELS;

  localparam logic KERNEL_SOBEL   = 1'b0;
  localparam logic KERNEL_PREWITT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_WAIT_RES,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sobel_win_fetch.sv
// 3x3 window fetcher: issues nine image RAM reads around (row, col) and
// captures each returned pixel into its window slot.
//
// Ports:
//   clk, rst     clock, async active-low reset
//   start        one-cycle pulse; the fetch runs in the following 10 cycles
//   row, col     centre pixel, held stable by the FSM for the whole fetch
//   rd_en        image RAM read strobe (first 9 fetch cycles)
//   rd_addr      image RAM address, 0 when not reading
//   rd_data      image RAM data, valid the cycle after rd_en
//   done         high in the 10th fetch cycle, when the last pixel lands
//   win_data     captured window, [7:0] = top-left, row-major
module sobel_win_fetch
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              done,
  output logic [WIN_W-1:0]  win_data
);

  logic             act_q, act_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;

  logic [ADDR_W-1:0] dy, dx, addr;

  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    win_d = win_q;
    if (start) begin
      act_d = 1'b1;
      cnt_d = 4'd0;
    end else if (act_q) begin
      if (cnt_q == 4'd9) begin
        act_d = 1'b0;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      // Data for read k is on rd_data during fetch cycle k+1.
      for (int i = 0; i < WIN_PIXELS; i++) begin
        if (cnt_q == 4'(i + 1)) win_d[i*PIX_W +: PIX_W] = rd_data;
      end
    end
  end

  always_comb begin
    dy   = ADDR_W'(cnt_q / 4'd3);
    dx   = ADDR_W'(cnt_q % 4'd3);
    // Interior pixels only, so row-1 and col-1 never underflow.
    addr = (row + dy - ADDR_W'(1)) * ADDR_W'(WIDTH) + (col + dx - ADDR_W'(1));
  end

  assign rd_en    = act_q && (cnt_q < 4'd9);
  assign rd_addr  = rd_en ? addr : '0;
  assign done     = act_q && (cnt_q == 4'd9);
  assign win_data = win_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q <= 1'b0;
      cnt_q <= 4'd0;
      win_q <= '0;
    end else begin
      act_q <= act_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer for the Sobel/Prewitt edge datapath. Raster-scans a
// WIDTH x HEIGHT image, fetches the 3x3 window for each interior pixel,
// hands it to the convolution engine, and writes the engine result (or 0
// for border pixels) to the output RAM.
//
// Ports:
//   clk, rst                   clock, async active-low reset
//   start, kernel_sel          frame start (IDLE only) and kernel choice
//   busy, done                 frame in progress / one-cycle completion pulse
//   rd_en, rd_addr, rd_data    image RAM read port (1-cycle latency)
//   win_valid, win_ready       window handshake to the engine
//   win_data, win_kernel       window pixels and latched kernel select
//   res_valid, res_ready       result handshake from the engine
//   res_pixel                  engine result
//   wr_en, wr_addr, wr_data    output RAM write port
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | waiting for start
// ST_FETCH    | 9 window reads + final capture (10 cycles)
// ST_PRESENT  | window offered until win_ready
// ST_WAIT_RES | waiting for res_valid, result captured
// ST_WRITE    | one output write, then advance raster position
// ST_DONE     | one-cycle done pulse
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int HEIGHT = 45,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kernel_sel,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic              win_kernel,
  input  logic              res_valid,
  input  logic [7:0]        res_pixel,
  output logic              res_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              kernel_q, kernel_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;

  logic fetch_start;
  logic fetch_done;
  logic last_pix;

  function automatic logic is_border(input logic [ADDR_W-1:0] r,
                                     input logic [ADDR_W-1:0] c);
    return (r == '0) || (r == ADDR_W'(HEIGHT - 1)) ||
           (c == '0) || (c == ADDR_W'(WIDTH - 1));
  endfunction

  assign last_pix = (row_q == ADDR_W'(HEIGHT - 1)) && (col_q == ADDR_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    kernel_d  = kernel_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          kernel_d  = kernel_sel;
          row_d     = '0;
          col_d     = '0;
          wr_data_d = '0;
          state_d   = is_border('0, '0) ? ST_WRITE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_done) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (win_ready) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (res_valid) begin
          wr_data_d = res_pixel;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Cleared so a following border write carries 0.
        wr_data_d = '0;
        if (last_pix) begin
          state_d = ST_DONE;
        end else begin
          if (col_q == ADDR_W'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + ADDR_W'(1);
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
          state_d = is_border(row_d, col_d) ? ST_WRITE : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulse on entry so the fetcher's 10 cycles line up with ST_FETCH.
  assign fetch_start = (state_d == ST_FETCH) && (state_q != ST_FETCH);

  sobel_win_fetch #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .start    (fetch_start),
    .row      (row_q),
    .col      (col_q),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .done     (fetch_done),
    .win_data (win_data)
  );

  assign busy       = (state_q == ST_FETCH) || (state_q == ST_PRESENT) ||
                      (state_q == ST_WAIT_RES) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign win_valid  = (state_q == ST_PRESENT);
  assign res_ready  = (state_q == ST_WAIT_RES);
  assign wr_en      = (state_q == ST_WRITE);
  assign wr_addr    = wr_en ? (row_q * ADDR_W'(WIDTH) + col_q) : '0;
  assign wr_data    = wr_data_q;
  assign win_kernel = kernel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      kernel_q  <= KERNEL_SOBEL;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      kernel_q  <= kernel_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int AW = 19;
  // Window of (1,1) in a 4-wide ramp image; [7:0] = top-left.
  localparam logic [71:0] W11 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W12 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0, kernel_sel = 1'b0;
  logic       win_ready = 1'b1, res_valid = 1'b1;
  logic [7:0] res_pixel = 8'h00;

  logic          busy_a, done_a, rd_en_a, win_valid_a, win_kernel_a, res_ready_a, wr_en_a;
  logic [AW-1:0] rd_addr_a, wr_addr_a;
  logic [7:0]    rd_data_a = 8'h00, wr_data_a;
  logic [71:0]   win_data_a;

  logic          busy_b, done_b, rd_en_b, win_valid_b, win_kernel_b, res_ready_b, wr_en_b;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [7:0]    rd_data_b = 8'h00, wr_data_b;
  logic [71:0]   win_data_b;

  sobel_frame_sequencer #(.WIDTH(4), .HEIGHT(3), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .kernel_sel(kernel_sel),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .win_valid(win_valid_a), .win_ready(win_ready),
    .win_data(win_data_a), .win_kernel(win_kernel_a), .res_valid(res_valid),
    .res_pixel(res_pixel), .res_ready(res_ready_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  sobel_frame_sequencer #(.WIDTH(45), .HEIGHT(45), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .kernel_sel(kernel_sel),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .win_valid(win_valid_b), .win_ready(win_ready),
    .win_data(win_data_b), .win_kernel(win_kernel_b), .res_valid(res_valid),
    .res_pixel(res_pixel), .res_ready(res_ready_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  // Ramp image RAMs: pixel = low byte of address, 1-cycle latency.
  always @(posedge clk) if (rd_en_a) rd_data_a <= rd_addr_a[7:0];
  always @(posedge clk) if (rd_en_b) rd_data_b <= rd_addr_b[7:0];

  logic [AW-1:0] wa_q[$], ra_q[$];
  logic [7:0]    wd_q[$];
  logic [71:0]   wv_q[$];
  int done_cnt_a = 0;
  always @(negedge clk) begin
    if (wr_en_a) begin
      wa_q.push_back(wr_addr_a);
      wd_q.push_back(wr_data_a);
    end
    if (rd_en_a) ra_q.push_back(rd_addr_a);
    if (win_valid_a) wv_q.push_back(win_data_a);
    if (done_a) done_cnt_a++;
  end

  int hits_b[2025];
  int wr_b = 0, zero_b = 0, aa_b = 0, other_b = 0, done_cnt_b = 0;
  always @(negedge clk) begin
    if (wr_en_b) begin
      wr_b++;
      if (wr_addr_b < AW'(2025)) hits_b[wr_addr_b]++;
      else other_b++;
      if (wr_data_b == 8'h00) zero_b++;
      else if (wr_data_b == 8'hAA) aa_b++;
      else other_b++;
    end
    if (done_b) done_cnt_b++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ev(input int sel);
    case (sel)
      0:       return done_a;
      1:       return win_valid_a;
      2:       return rd_en_a;
      3:       return res_ready_a;
      4:       return wr_en_a && (wr_addr_a == AW'(5));
      default: return done_b;
    endcase
  endfunction

  // Call at a sample point; returns edges waited before the event held.
  task automatic wait_for(input int sel, input int budget, output int n);
    n = 0;
    while (!ev(sel) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("wait_event%0d", sel), ev(sel), 1'b1);
  endtask

  task automatic start_frame_a(input logic k);
    @(negedge clk);
    kernel_sel = k;
    start_a    = 1'b1;
    @(posedge clk); #1;
    start_a    = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input int w0, input logic [7:0] v);
    int hits[12];
    int bad_a, bad_v;
    logic [7:0] e;
    bad_a = 0;
    bad_v = 0;
    for (int i = 0; i < 12; i++) hits[i] = 0;
    for (int i = w0; i < wa_q.size(); i++) begin
      if (wa_q[i] < AW'(12)) hits[wa_q[i]]++;
      else bad_a++;
      e = (wa_q[i] == AW'(5) || wa_q[i] == AW'(6)) ? v : 8'h00;
      if (wd_q[i] !== e) bad_v++;
    end
    for (int i = 0; i < 12; i++) if (hits[i] != 1) bad_a++;
    check({tag, "_writes"}, wa_q.size() - w0, 12);
    check({tag, "_addr_once"}, bad_a, 0);
    check({tag, "_values"}, bad_v, 0);
  endtask

  initial begin
    int n, w0, r0, v0, d0, bad;
    int exp11[9];
    int exp12[9];
    exp11 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp12 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    // Reset state
    #3;
    check("rst_ctrl", {busy_a, done_a, rd_en_a, win_valid_a, res_ready_a, wr_en_a}, 6'b0);
    check("rst_addr", {rd_addr_a, wr_addr_a, wr_data_a}, 0);
    check("rst_win", {win_data_a, win_kernel_a}, 0);
    #9 rst = 1'b1;

    // 1: 4x3 zero-wait ramp, Prewitt
    win_ready = 1'b1; res_valid = 1'b1; res_pixel = 8'h5A;
    w0 = wa_q.size(); r0 = ra_q.size(); v0 = wv_q.size(); d0 = done_cnt_a;
    start_frame_a(KERNEL_PREWITT);
    check("t1_first_write", {busy_a, wr_en_a, wr_addr_a}, {1'b1, 1'b1, AW'(0)});
    wait_for(0, 200, n);
    check("t1_done_cycle", n + 1, 37);
    @(posedge clk); #1;
    check("t1_after_done", {busy_a, done_a}, 2'b00);
    check("t1_kernel", win_kernel_a, KERNEL_PREWITT);
    check("t1_reads", ra_q.size() - r0, 18);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (ra_q[r0 + i] !== AW'(exp11[i])) bad++;
      if (ra_q[r0 + 9 + i] !== AW'(exp12[i])) bad++;
    end
    check("t1_rd_seq", bad, 0);
    check("t1_win11", wv_q[v0], W11);
    check("t1_win12", wv_q[v0 + 1], W12);
    check("t1_done_once", done_cnt_a - d0, 1);
    check_frame_a("t1", w0, 8'h5A);

    // 2: win_ready stalled 5 cycles; start and kernel_sel toggled mid-frame
    win_ready = 1'b0; res_valid = 1'b1; res_pixel = 8'h33;
    w0 = wa_q.size(); d0 = done_cnt_a;
    start_frame_a(KERNEL_SOBEL);
    wait_for(1, 50, n);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_stall%0d", i), {win_valid_a, rd_en_a, wr_en_a, win_data_a},
            {1'b1, 1'b0, 1'b0, W11});
      if (i == 1) begin
        kernel_sel = 1'b1;
        start_a    = 1'b1;
      end
      check($sformatf("t2_kernel%0d", i), win_kernel_a, KERNEL_SOBEL);
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    win_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_wait_res", {res_ready_a, win_valid_a}, 2'b10);
    @(posedge clk); #1;
    check("t2_write", {wr_en_a, wr_addr_a, wr_data_a}, {1'b1, AW'(5), 8'h33});
    start_a = 1'b0;
    wait_for(0, 200, n);
    check("t2_kernel_end", win_kernel_a, KERNEL_SOBEL);
    @(posedge clk); #1;
    check("t2_done_once", done_cnt_a - d0, 1);
    check_frame_a("t2", w0, 8'h33);

    // 3: res_valid pulse during FETCH must be ignored
    res_valid = 1'b0; win_ready = 1'b1;
    w0 = wa_q.size();
    start_frame_a(KERNEL_SOBEL);
    wait_for(2, 50, n);
    res_valid = 1'b1; res_pixel = 8'hEE;
    @(posedge clk); #1;
    res_valid = 1'b0;
    wait_for(3, 50, n);
    check("t3_hold0", {res_ready_a, wr_en_a}, 2'b10);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t3_hold%0d", i), {res_ready_a, wr_en_a}, 2'b10);
    end
    res_valid = 1'b1; res_pixel = 8'h77;
    @(posedge clk); #1;
    check("t3_write", {wr_en_a, wr_addr_a, wr_data_a}, {1'b1, AW'(5), 8'h77});
    wait_for(0, 200, n);
    @(posedge clk); #1;
    check_frame_a("t3", w0, 8'h77);

    // 4: async reset during FETCH of (1,2), then a clean rerun
    res_valid = 1'b1; win_ready = 1'b1; res_pixel = 8'h44;
    start_frame_a(KERNEL_PREWITT);
    wait_for(4, 50, n);
    @(posedge clk); #1;
    check("t4_fetch12_a", {rd_en_a, rd_addr_a}, {1'b1, AW'(1)});
    @(posedge clk); #1;
    check("t4_fetch12_b", {rd_en_a, rd_addr_a}, {1'b1, AW'(2)});
    #2 rst = 1'b0;
    #1;
    check("t4_rst_ctrl", {busy_a, done_a, rd_en_a, win_valid_a, res_ready_a, wr_en_a}, 6'b0);
    check("t4_rst_addr", {rd_addr_a, wr_addr_a, wr_data_a}, 0);
    check("t4_rst_win", {win_data_a, win_kernel_a}, 0);
    w0 = wa_q.size(); d0 = done_cnt_a;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_idle", {busy_a, rd_en_a, wr_en_a}, 3'b000);
    check("t4_no_writes", wa_q.size() - w0, 0);
    check("t4_no_done", done_cnt_a - d0, 0);
    r0 = ra_q.size();
    start_frame_a(KERNEL_SOBEL);
    check("t4_rerun_first", {busy_a, wr_en_a, wr_addr_a}, {1'b1, 1'b1, AW'(0)});
    wait_for(0, 200, n);
    check("t4_done_cycle", n + 1, 37);
    @(posedge clk); #1;
    check("t4_rerun_rd0", ra_q[r0], AW'(0));
    check_frame_a("t4", w0, 8'h44);

    // 5: 45x45 zero-wait, engine returns 0xAA
    res_valid = 1'b1; win_ready = 1'b1; res_pixel = 8'hAA;
    @(negedge clk);
    kernel_sel = KERNEL_SOBEL;
    start_b    = 1'b1;
    @(posedge clk); #1;
    start_b    = 1'b0;
    wait_for(5, 30000, n);
    check("t5_done_cycle", n + 1, 176 + 13 * 1849 + 1);
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 2025; i++) if (hits_b[i] != 1) bad++;
    check("t5_writes", wr_b, 2025);
    check("t5_addr_once", bad, 0);
    check("t5_zeros", zero_b, 176);
    check("t5_aa", aa_b, 1849);
    check("t5_other", other_b, 0);
    check("t5_done_once", done_cnt_b, 1);
    check("t5_idle", busy_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
